// File: rtl/fwrisc_trace_driver.sv
// Trace record FIFO that replays queued records onto registered retire/regwrite/memwrite strobes.
// Optional build macro FWRISC_TRACE_DRIVER_X0_FILTER_EN drops register writes that target x0.
module fwrisc_trace_driver #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rec_valid,
    output logic        rec_ready,
    input  logic [1:0]  rec_kind,
    input  logic [31:0] rec_addr,
    input  logic [31:0] rec_data,
    input  logic [5:0]  rec_aux,
    input  logic        pause,
    input  logic        flush,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        ivalid,
    output logic [5:0]  rd_waddr,
    output logic [31:0] rd_wdata,
    output logic        rd_write,
    output logic [31:0] maddr,
    output logic [31:0] mdata,
    output logic [3:0]  mstrb,
    output logic        mwrite,
    output logic        mvalid,
    output logic [31:0] emit_count,
    output logic [15:0] drop_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EMIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [1:0] K_INSTR = 2'd0;
    localparam logic [1:0] K_REG   = 2'd1;
    localparam logic [1:0] K_MEM   = 2'd2;

`ifdef FWRISC_TRACE_DRIVER_X0_FILTER_EN
    localparam bit X0_FILTER = 1'b1;
`else
    localparam bit X0_FILTER = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic [5:0]  aux;
    } rec_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    rec_t            mem_q [DEPTH];
    rec_t            head;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [1:0]      state_q, state_d;
    logic            push, pop, emit_i, emit_r, emit_m, drop;

    logic [31:0] pc_q, pc_d, instr_q, instr_d, rd_wdata_q, rd_wdata_d;
    logic [31:0] maddr_q, maddr_d, mdata_q, mdata_d, emit_count_q, emit_count_d;
    logic [5:0]  rd_waddr_q, rd_waddr_d;
    logic [3:0]  mstrb_q, mstrb_d;
    logic [15:0] drop_count_q, drop_count_d;
    logic        ivalid_q, ivalid_d, rd_write_q, rd_write_d, mvalid_q, mvalid_d;

    always_comb begin
        rec_ready = reset && !flush && (count_q < DEPTH_C);
        push      = rec_valid && rec_ready;
        pop       = (count_q != '0) && !pause && !flush;
        head      = mem_q[rd_ptr_q];
        emit_i    = pop && (head.kind == K_INSTR);
        emit_r    = pop && (head.kind == K_REG) && !(X0_FILTER && (head.aux == 6'd0));
        emit_m    = pop && (head.kind == K_MEM);
        drop      = pop && !emit_i && !emit_r && !emit_m;
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        // Flush drops everything queued; push is already blocked by rec_ready.
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end

        state_d = state_q;
        if (flush)                          state_d = ST_IDLE;
        else if (pop)                       state_d = ST_EMIT;
        else if (pause && count_q != '0)    state_d = ST_HOLD;
        else if (count_q == '0)             state_d = ST_IDLE;
    end

    always_comb begin
        ivalid_d     = emit_i;
        rd_write_d   = emit_r;
        mvalid_d     = emit_m;
        pc_d         = pc_q;
        instr_d      = instr_q;
        rd_waddr_d   = rd_waddr_q;
        rd_wdata_d   = rd_wdata_q;
        maddr_d      = maddr_q;
        mdata_d      = mdata_q;
        mstrb_d      = mstrb_q;
        emit_count_d = emit_count_q + 32'(emit_i || emit_r || emit_m);
        drop_count_d = drop ? sat_inc16(drop_count_q) : drop_count_q;
        if (emit_i) begin
            pc_d    = head.addr;
            instr_d = head.data;
        end
        if (emit_r) begin
            rd_waddr_d = head.aux;
            rd_wdata_d = head.data;
        end
        if (emit_m) begin
            maddr_d = head.addr;
            mdata_d = head.data;
            mstrb_d = head.aux[3:0];
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= rec_t'({rec_kind, rec_addr, rec_data, rec_aux});
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= ST_IDLE;
            ivalid_q     <= 1'b0;
            rd_write_q   <= 1'b0;
            mvalid_q     <= 1'b0;
            pc_q         <= '0;
            instr_q      <= '0;
            rd_waddr_q   <= '0;
            rd_wdata_q   <= '0;
            maddr_q      <= '0;
            mdata_q      <= '0;
            mstrb_q      <= '0;
            emit_count_q <= '0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            ivalid_q     <= ivalid_d;
            rd_write_q   <= rd_write_d;
            mvalid_q     <= mvalid_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            rd_waddr_q   <= rd_waddr_d;
            rd_wdata_q   <= rd_wdata_d;
            maddr_q      <= maddr_d;
            mdata_q      <= mdata_d;
            mstrb_q      <= mstrb_d;
            emit_count_q <= emit_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign pc         = pc_q;
    assign instr      = instr_q;
    assign ivalid     = ivalid_q;
    assign rd_waddr   = rd_waddr_q;
    assign rd_wdata   = rd_wdata_q;
    assign rd_write   = rd_write_q;
    assign maddr      = maddr_q;
    assign mdata      = mdata_q;
    assign mstrb      = mstrb_q;
    assign mvalid     = mvalid_q;
    assign mwrite     = mvalid_q;
    assign emit_count = emit_count_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_fwrisc_trace_driver.sv
// Directed bench for fwrisc_trace_driver: a record queue scoreboard checks every cycle, plus directed timing checks.
module tb_fwrisc_trace_driver;

    localparam int DEPTH = 4;
`ifdef FWRISC_TRACE_DRIVER_X0_FILTER_EN
    localparam bit X0F = 1'b1;
`else
    localparam bit X0F = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rec_valid = 1'b0;
    logic [1:0]  rec_kind = 2'd0;
    logic [31:0] rec_addr = 32'd0;
    logic [31:0] rec_data = 32'd0;
    logic [5:0]  rec_aux = 6'd0;
    logic        pause = 1'b0;
    logic        flush = 1'b0;
    logic        rec_ready, ivalid, rd_write, mwrite, mvalid;
    logic [31:0] pc, instr, rd_wdata, maddr, mdata, emit_count;
    logic [5:0]  rd_waddr;
    logic [3:0]  mstrb;
    logic [15:0] drop_count;

    fwrisc_trace_driver #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind),
        .rec_addr(rec_addr), .rec_data(rec_data), .rec_aux(rec_aux),
        .pause(pause), .flush(flush),
        .pc(pc), .instr(instr), .ivalid(ivalid),
        .rd_waddr(rd_waddr), .rd_wdata(rd_wdata), .rd_write(rd_write),
        .maddr(maddr), .mdata(mdata), .mstrb(mstrb), .mwrite(mwrite), .mvalid(mvalid),
        .emit_count(emit_count), .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic [5:0]  aux;
    } rec_t;

    rec_t        m_fifo[$];
    rec_t        s_r;
    logic        s_pop, s_push;
    int          n_vec = 0;
    int          n_err = 0;
    logic        exp_i = 1'b0, exp_r = 1'b0, exp_m = 1'b0;
    logic [31:0] m_pc = '0, m_instr = '0, m_rdd = '0, m_maddr = '0, m_mdata = '0;
    logic [5:0]  m_rda = '0;
    logic [3:0]  m_strb = '0;
    logic [31:0] m_emit = '0;
    logic [15:0] m_drop = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic any_strobe();
        return ivalid | rd_write | mvalid;
    endfunction

    // Scoreboard: records enter the queue on acceptance and leave on pop.
    initial forever begin
        @(posedge clock or negedge reset);
        if (!reset) begin
            m_fifo.delete();
            exp_i = 1'b0; exp_r = 1'b0; exp_m = 1'b0;
            m_pc = '0; m_instr = '0; m_rdd = '0; m_rda = '0;
            m_maddr = '0; m_mdata = '0; m_strb = '0;
            m_emit = '0; m_drop = '0;
        end else begin
            s_pop  = (m_fifo.size() > 0) && !pause && !flush;
            s_push = rec_valid && !flush && (m_fifo.size() < DEPTH);
            exp_i = 1'b0; exp_r = 1'b0; exp_m = 1'b0;
            if (flush) begin
                m_fifo.delete();
            end else if (s_pop) begin
                s_r = m_fifo.pop_front();
                if (s_r.kind == 2'd0) begin
                    exp_i = 1'b1; m_pc = s_r.addr; m_instr = s_r.data; m_emit++;
                end else if (s_r.kind == 2'd1 && !(X0F && s_r.aux == 6'd0)) begin
                    exp_r = 1'b1; m_rda = s_r.aux; m_rdd = s_r.data; m_emit++;
                end else if (s_r.kind == 2'd2) begin
                    exp_m = 1'b1; m_maddr = s_r.addr; m_mdata = s_r.data; m_strb = s_r.aux[3:0]; m_emit++;
                end else if (m_drop != 16'hFFFF) begin
                    m_drop++;
                end
            end
            if (s_push) m_fifo.push_back('{rec_kind, rec_addr, rec_data, rec_aux});
        end
    end

    initial forever begin
        @(negedge clock);
        check("rec_ready", 32'(rec_ready), 32'(reset && !flush && (m_fifo.size() < DEPTH)));
        check("ivalid",    32'(ivalid),    32'(exp_i));
        check("rd_write",  32'(rd_write),  32'(exp_r));
        check("mvalid",    32'(mvalid),    32'(exp_m));
        check("mwrite",    32'(mwrite),    32'(exp_m));
        check("pc",        pc,             m_pc);
        check("instr",     instr,          m_instr);
        check("rd_waddr",  32'(rd_waddr),  32'(m_rda));
        check("rd_wdata",  rd_wdata,       m_rdd);
        check("maddr",     maddr,          m_maddr);
        check("mdata",     mdata,          m_mdata);
        check("mstrb",     32'(mstrb),     32'(m_strb));
        check("emit_count", emit_count,    m_emit);
        check("drop_count", 32'(drop_count), 32'(m_drop));
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic drive(input logic [1:0] k, input logic [31:0] a, input logic [31:0] d, input logic [5:0] x);
        rec_valid = 1'b1; rec_kind = k; rec_addr = a; rec_data = d; rec_aux = x;
    endtask

    task automatic idle();
        rec_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    logic [1:0] kinds [8] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2};

    initial begin
        #1 reset = 1'b0;
        #1;
        check("rst_ready",  32'(rec_ready), 32'd0);
        check("rst_strobe", 32'(any_strobe()), 32'd0);
        check("rst_pc",     pc, 32'd0);
        check("rst_emit",   emit_count, 32'd0);
        check("rst_drop",   32'(drop_count), 32'd0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // Single instruction record into an empty FIFO
        drive(2'd0, 32'h8000_0000, 32'h0000_0013, 6'd0);
        check("t1_ready", 32'(rec_ready), 32'd1);
        tick();
        idle();
        check("t1_early", 32'(any_strobe()), 32'd0);
        tick();
        check("t1_ivalid", 32'(ivalid), 32'd1);
        check("t1_pc",     pc, 32'h8000_0000);
        check("t1_instr",  instr, 32'h0000_0013);
        check("t1_emit",   emit_count, 32'd1);
        tick();
        check("t1_pulse",  32'(ivalid), 32'd0);
        check("t1_hold",   pc, 32'h8000_0000);
        do_reset();

        // Back-to-back stream of mixed records
        for (int i = 0; i < 8; i++) begin
            drive(kinds[i], 32'h1000_0000 + 32'(i * 4), 32'hA5A5_0000 + 32'(i), 6'(i + 1));
            check("t2_ready", 32'(rec_ready), 32'd1);
            tick();
            if (i > 0) check("t2_stream", 32'(any_strobe()), 32'd1);
        end
        idle();
        tick();
        check("t2_last", 32'(any_strobe()), 32'd1);
        check("t2_mdata", mdata, 32'hA5A5_0007);
        tick();
        check("t2_done", 32'(any_strobe()), 32'd0);
        check("t2_emit", emit_count, 32'd8);
        do_reset();

        // Fill under pause, hold, then release
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(kinds[i], 32'h2000_0000 + 32'(i), 32'h5A00_0000 + 32'(i), 6'(i + 9));
            check("t3_ready", 32'(rec_ready), 32'd1);
            tick();
        end
        drive(2'd0, 32'hBAD0_0000, 32'hBAD0_0000, 6'd1);
        check("t3_full", 32'(rec_ready), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_hold_strobe", 32'(any_strobe()), 32'd0);
            check("t3_hold_ready",  32'(rec_ready), 32'd0);
        end
        idle();
        pause = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_release", 32'(any_strobe()), 32'd1);
        end
        tick();
        check("t3_done", 32'(any_strobe()), 32'd0);
        check("t3_emit", emit_count, 32'd4);
        check("t3_ready_after", 32'(rec_ready), 32'd1);
        do_reset();

        // Register write to x0, then a reserved record
        drive(2'd1, 32'h0, 32'hDEAD_BEEF, 6'd0);
        tick();
        idle();
        tick();
        check("t4_rd_write", 32'(rd_write), 32'(!X0F));
        check("t4_rd_wdata", rd_wdata, X0F ? 32'd0 : 32'hDEAD_BEEF);
        check("t4_emit", emit_count, X0F ? 32'd0 : 32'd1);
        check("t4_drop", 32'(drop_count), X0F ? 32'd1 : 32'd0);
        drive(2'd3, 32'h1234_5678, 32'h8765_4321, 6'h3F);
        tick();
        idle();
        tick();
        check("t4_rsvd_strobe", 32'(any_strobe()), 32'd0);
        check("t4_rsvd_drop", 32'(drop_count), X0F ? 32'd2 : 32'd1);
        check("t4_rsvd_hold", rd_wdata, X0F ? 32'd0 : 32'hDEAD_BEEF);

        // Flush three queued records
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(2'd2, 32'h3000_0000 + 32'(i), 32'h7700_0000 + 32'(i), 6'h0F);
            tick();
        end
        idle();
        flush = 1'b1;
        #1;
        check("t5_flush_ready", 32'(rec_ready), 32'd0);
        tick();
        flush = 1'b0;
        pause = 1'b0;
        tick();
        check("t5_no_strobe1", 32'(any_strobe()), 32'd0);
        tick();
        check("t5_no_strobe2", 32'(any_strobe()), 32'd0);
        check("t5_emit", emit_count, X0F ? 32'd0 : 32'd1);
        check("t5_ready", 32'(rec_ready), 32'd1);
        drive(2'd0, 32'h4000_0000, 32'h0000_0093, 6'd0);
        tick();
        idle();
        tick();
        check("t5_after_ivalid", 32'(ivalid), 32'd1);
        check("t5_after_pc", pc, 32'h4000_0000);

        // Reset asserted mid-stream
        drive(2'd2, 32'h5000_0000, 32'h1111_1111, 6'h03);
        tick();
        drive(2'd1, 32'h0, 32'h2222_2222, 6'd5);
        tick();
        drive(2'd0, 32'h5000_0008, 32'h3333_3333, 6'd0);
        #1 reset = 1'b0;
        #1;
        check("t6_strobe", 32'(any_strobe()), 32'd0);
        check("t6_pc",     pc, 32'd0);
        check("t6_maddr",  maddr, 32'd0);
        check("t6_mdata",  mdata, 32'd0);
        check("t6_wdata",  rd_wdata, 32'd0);
        check("t6_emit",   emit_count, 32'd0);
        check("t6_drop",   32'(drop_count), 32'd0);
        check("t6_ready",  32'(rec_ready), 32'd0);
        idle();
        tick();
        reset = 1'b1;
        tick();
        check("t6_no_stale", 32'(any_strobe()), 32'd0);
        drive(2'd0, 32'hCAFE_0000, 32'h0000_0073, 6'd0);
        tick();
        idle();
        check("t6_early", 32'(any_strobe()), 32'd0);
        tick();
        check("t6_ivalid", 32'(ivalid), 32'd1);
        check("t6_pc2",    pc, 32'hCAFE_0000);
        check("t6_emit2",  emit_count, 32'd1);
        tick();
        tick();
        check("drain", 32'(m_fifo.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
